// File: rtl/anode_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package : disp_pkg
//  Shared definitions for the 8-digit 7-segment display blocks: digit count,
//  select width, the all-anodes-off pattern, default refresh divider, and
//  the cyclic "next enabled digit" search used by the scan controller.
//  Revision: 1.0  initial release
// ============================================================================
package disp_pkg;

  localparam int NUM_DIGITS    = 8;
  localparam int SEL_W         = 3;
  localparam int DIV_DEFAULT   = 100000;  // 100 MHz -> 1 kHz per digit
  localparam int DIV_W_DEFAULT = 17;

  typedef logic [SEL_W-1:0]      sel_t;
  typedef logic [NUM_DIGITS-1:0] mask_t;

  localparam mask_t AN_OFF = 8'hFF;

  // Returns the first enabled index after sel, searching sel+1 .. sel+7
  // cyclically. When no other digit is enabled (including an empty mask)
  // sel itself is returned, so the scan holds.
  function automatic sel_t next_enabled(input sel_t sel, input mask_t mask);
    sel_t cand;
    sel_t res;
    res = sel;
    // Walk offsets from far to near so the nearest enabled digit wins.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      cand = sel + SEL_W'(i);
      if (mask[cand]) res = cand;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/anode_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface : anode_scan_ctrl_if
//  Bundles the scan controller's control inputs and display outputs.
//    digit_en [7:0]  per-digit enable mask (bit i = digit i)
//    blank           1 = all anodes off, scanning continues
//    bright   [3:0]  PWM duty level (only when ANODE_PWM_EN is defined)
//    sel      [2:0]  digit index to the nibble mux
//    an       [7:0]  active-low anode enables
//    tick            one-cycle strobe per slot boundary
//  master = the side driving the controls, slave = the scan controller.
//  Optional feature macro: ANODE_PWM_EN
//  Revision: 1.0  initial release
// ============================================================================
interface anode_scan_ctrl_if
  import disp_pkg::*;
  ();

  mask_t       digit_en;
  logic        blank;
`ifdef ANODE_PWM_EN
  logic [3:0]  bright;
`endif
  sel_t        sel;
  mask_t       an;
  logic        tick;

`ifdef ANODE_PWM_EN
  modport master (output digit_en, output blank, output bright,
                  input sel, input an, input tick);
  modport slave  (input digit_en, input blank, input bright,
                  output sel, output an, output tick);
`else
  modport master (output digit_en, output blank,
                  input sel, input an, input tick);
  modport slave  (input digit_en, input blank,
                  output sel, output an, output tick);
`endif

endinterface
`default_nettype wire

// File: rtl/anode_scan_ctrl_tick.sv
`default_nettype none
// ============================================================================
//  Module  : refresh_tick
//  Refresh divider: counts 0..DIV-1 and wraps. wrap_o is combinational and
//  high during the last cycle of a slot, so owners of slot state can load on
//  the boundary edge; tick_o is the registered strobe in the following cycle.
//  Ports:
//    clk     in   system clock
//    reset   in   synchronous active-high reset
//    wrap_o  out  cnt == DIV-1 (combinational)
//    tick_o  out  registered slot-boundary pulse
//  Parameters: DIV (>= 2) cycles per slot, DIV_W counter width
//  Revision: 1.0  initial release
// ============================================================================
module refresh_tick #(
  parameter int DIV   = 100000,
  parameter int DIV_W = 17
) (
  input  logic clk,
  input  logic reset,
  output logic wrap_o,
  output logic tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             tick_q;

  assign wrap_o = (cnt_q == DIV_W'(DIV - 1));
  assign cnt_d  = wrap_o ? '0 : cnt_q + DIV_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap_o;
    end
  end

  assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/anode_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : anode_scan_ctrl
//  Time-multiplexing controller for an 8-digit 7-segment display. Produces
//  the digit select for the nibble mux and the matching active-low anodes,
//  both registered on the same edge so they never skew. Disabled digits are
//  skipped; blank turns every anode off while the scan keeps running.
//  Ports:
//    clk     in   system clock
//    reset   in   synchronous active-high reset
//    bus_if  slave modport of anode_scan_ctrl_if
//              (digit_en, blank, [bright] in; sel, an, tick out)
//  Parameters: DIV (>= 2) cycles per digit slot, DIV_W divider width
//  Optional feature macro: ANODE_PWM_EN (brightness PWM on the lit anode)
//  Revision: 1.0  initial release
// ============================================================================
module anode_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  anode_scan_ctrl_if.slave   bus_if
);

  logic  slot_wrap;
  logic  slot_tick;
  sel_t  sel_q, sel_d;
  mask_t an_q, an_d;
  logic  lit;

  refresh_tick #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_refresh_tick (
    .clk    (clk),
    .reset  (reset),
    .wrap_o (slot_wrap),
    .tick_o (slot_tick)
  );

  // The select only moves on a slot boundary; mid-slot mask changes affect
  // the anodes immediately but wait for the boundary to re-target sel.
  assign sel_d = slot_wrap ? next_enabled(sel_q, bus_if.digit_en) : sel_q;

`ifdef ANODE_PWM_EN
  logic [3:0] pwm_cnt_q;
  logic [3:0] pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + 4'd1;

  // Compare against the value the counter takes on this edge so the
  // registered anode lines up with the registered PWM phase.
  assign lit = bus_if.digit_en[sel_d] && !bus_if.blank
               && (pwm_cnt_d <= bus_if.bright);

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt_q <= 4'd0;
    else       pwm_cnt_q <= pwm_cnt_d;
  end
`else
  assign lit = bus_if.digit_en[sel_d] && !bus_if.blank;
`endif

  // Anodes are computed from sel_d so they land on the same edge as sel.
  assign an_d = lit ? ~(mask_t'(1) << sel_d) : AN_OFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
      an_q  <= AN_OFF;
    end else begin
      sel_q <= sel_d;
      an_q  <= an_d;
    end
  end

  assign bus_if.sel  = sel_q;
  assign bus_if.an   = an_q;
  assign bus_if.tick = slot_tick;

endmodule
`default_nettype wire

// File: tb/tb_anode_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_anode_scan_ctrl
//  Self-checking bench for anode_scan_ctrl: directed slot table, hand-written
//  multi-cycle corner cases, and randomized stimulus against a reference
//  model. Optional feature macro: ANODE_PWM_EN
//  Revision: 1.0  initial release
// ============================================================================
module tb_anode_scan_ctrl;
  import disp_pkg::*;

`ifdef ANODE_PWM_EN
  localparam int DIV = 64;
`else
  localparam int DIV = 4;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  anode_scan_ctrl_if bus ();

  anode_scan_ctrl #(
    .DIV   (DIV),
    .DIV_W (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_next(input int s, input logic [7:0] m);
    for (int j = 1; j <= 8; j++)
      if (m[(s + j) % 8]) return (s + j) % 8;
    return s;
  endfunction

  function automatic logic [7:0] ref_an(input int s, input logic [7:0] m,
                                        input logic b, input int p, input int br);
    logic [7:0] v;
    v = 8'hFF;
    if (m[s] && !b && p <= br) v[s] = 1'b0;
    return v;
  endfunction

  int         m_pos = 0;
  int         m_sel = 0;
  int         m_pwm = 0;
  logic [7:0] m_an  = 8'hFF;
  logic       m_tick = 1'b0;

  always @(posedge clk) begin
    int br;
`ifdef ANODE_PWM_EN
    br = int'(bus.bright);
`else
    br = 15;
`endif
    if (reset) begin
      m_pos = 0; m_sel = 0; m_pwm = 0; m_an = 8'hFF; m_tick = 1'b0;
    end else begin
      m_tick = (m_pos == DIV - 1);
      if (m_pos == DIV - 1) begin
        m_sel = ref_next(m_sel, bus.digit_en);
        m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
      m_pwm = (m_pwm + 1) % 16;
      m_an  = ref_an(m_sel, bus.digit_en, bus.blank, m_pwm, br);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.tick && k < 4 * DIV);
    if (!bus.tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_sel(input logic [2:0] s);
    int k;
    k = 0;
    while (bus.sel !== s && k < 10) begin
      wait_tick();
      k++;
    end
    chk("reach_sel", 32'(bus.sel), 32'(s));
  endtask

  typedef struct {
    logic [7:0] en;
    logic       blank;
    logic [2:0] sel;
    logic [7:0] an;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int low;
    logic [7:0] e;

    // slot table: inputs applied during a slot, values seen at its end
    tbl.push_back('{8'hFF, 1'b0, 3'd1, 8'hFD});
    tbl.push_back('{8'hFF, 1'b0, 3'd2, 8'hFB});
    tbl.push_back('{8'hFF, 1'b0, 3'd3, 8'hF7});
    tbl.push_back('{8'hFF, 1'b0, 3'd4, 8'hEF});
    tbl.push_back('{8'hFF, 1'b0, 3'd5, 8'hDF});
    tbl.push_back('{8'hFF, 1'b0, 3'd6, 8'hBF});
    tbl.push_back('{8'hFF, 1'b0, 3'd7, 8'h7F});
    tbl.push_back('{8'hFF, 1'b0, 3'd0, 8'hFE});
    tbl.push_back('{8'h85, 1'b0, 3'd2, 8'hFB});
    tbl.push_back('{8'h85, 1'b0, 3'd7, 8'h7F});
    tbl.push_back('{8'h85, 1'b0, 3'd0, 8'hFE});
    tbl.push_back('{8'h85, 1'b0, 3'd2, 8'hFB});
    tbl.push_back('{8'h00, 1'b0, 3'd2, 8'hFF});
    tbl.push_back('{8'h00, 1'b0, 3'd2, 8'hFF});
    tbl.push_back('{8'hFF, 1'b1, 3'd3, 8'hFF});
    tbl.push_back('{8'hFF, 1'b1, 3'd4, 8'hFF});
    tbl.push_back('{8'hFF, 1'b0, 3'd5, 8'hDF});

    reset        = 1'b1;
    bus.digit_en = 8'hFF;
    bus.blank    = 1'b0;
`ifdef ANODE_PWM_EN
    bus.bright   = 4'hF;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sel",  32'(bus.sel),  32'd0);
    chk("rst_an",   32'(bus.an),   32'hFF);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_an",  32'(bus.an),  32'hFE);
    chk("first_sel", 32'(bus.sel), 32'd0);

    foreach (tbl[i]) begin
      bus.digit_en = tbl[i].en;
      bus.blank    = tbl[i].blank;
      wait_tick();
      chk($sformatf("tbl%0d_sel", i), 32'(bus.sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_an",  i), 32'(bus.an),  32'(tbl[i].an));
    end

    // tick period
    wait_tick();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.tick && k < 4 * DIV);
    chk("tick_period", 32'(k), 32'(DIV));

    // digit disabled mid-slot
    wait_sel(3'd3);
    @(negedge clk);
    chk("mid_an_lit", 32'(bus.an), 32'hF7);
    bus.digit_en = 8'hF7;
    @(negedge clk);
    chk("mid_an_off", 32'(bus.an),  32'hFF);
    chk("mid_sel",    32'(bus.sel), 32'd3);
    wait_tick();
    chk("mid_next_sel", 32'(bus.sel), 32'd4);
    chk("mid_next_an",  32'(bus.an),  32'hEF);
    bus.digit_en = 8'hFF;

    // blank for 10 clocks
    bus.blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("blank_an",  32'(bus.an),  32'hFF);
      chk("blank_sel", 32'(bus.sel), 32'(m_sel));
    end
    bus.blank = 1'b0;
    @(negedge clk);
    e = 8'hFF;
    e[m_sel] = 1'b0;
    chk("unblank_an", 32'(bus.an), 32'(e));

    // reset mid-slot at sel=5
    wait_sel(3'd5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_sel",  32'(bus.sel),  32'd0);
    chk("mrst_an",   32'(bus.an),   32'hFF);
    chk("mrst_tick", 32'(bus.tick), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_lit0", 32'(bus.an), 32'hFE);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.tick && k < 4 * DIV);
    chk("mrst_full_slot", 32'(k), 32'(DIV - 1));

    // randomized stimulus against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7, 0) == 0) bus.digit_en = 8'($urandom);
      if ($urandom_range(9, 0) == 0) bus.blank = ~bus.blank;
`ifdef ANODE_PWM_EN
      if ($urandom_range(15, 0) == 0) bus.bright = 4'($urandom);
`endif
      @(negedge clk);
      chk("rnd_sel",  32'(bus.sel),  32'(m_sel));
      chk("rnd_an",   32'(bus.an),   32'(m_an));
      chk("rnd_tick", 32'(bus.tick), 32'(m_tick));
    end

`ifdef ANODE_PWM_EN
    // PWM duty: bright=3 -> 4 of 16, bright=0 -> 1 of 16
    bus.digit_en = 8'hFF;
    bus.blank    = 1'b0;
    bus.bright   = 4'h3;
    @(negedge clk);
    low = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.an != 8'hFF) low++;
    end
    chk("pwm_duty3", 32'(low), 32'd16);
    bus.bright = 4'h0;
    @(negedge clk);
    low = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.an != 8'hFF) low++;
    end
    chk("pwm_duty0", 32'(low), 32'd4);
`else
    low = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
